// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle for spi_reg_bank.
//   sclk, ncs, copi : controller -> peripheral (asynchronous to the peripheral clock)
//   cipo, cipo_oe   : peripheral -> controller read data and its pad output enable
interface spi_reg_bank_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral holding a bank of NUM_REGS configuration registers.
// Frames are {rw, addr[ADDR_W], data[DATA_W]}, MSB first; rw=1 writes, rw=0 reads
// the addressed register back on cipo during the data phase.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi        : SPI pins (slave modport), all sampled through synchronisers
//   regs_flat  : register k at [k*DATA_W +: DATA_W]
//   wr_strobe  : one-clk pulse on bit k when register k is written
//   frame_err  : one-clk pulse when a frame ends with the wrong bit count
module spi_reg_bank #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_reg_bank_if.slave                spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  // Synchronisers plus one edge-detect flop; reset low so a frame already
  // in progress at reset release never produces an ncs falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_d, ncs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise_c, sclk_fall_c, ncs_rise_c, ncs_fall_c;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync[SYNC_STAGES-1];
  assign copi_s      = copi_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign ncs_rise_c  = ncs_s & ~ncs_d;
  assign ncs_fall_c  = ~ncs_s & ncs_d;

  // Frame state
  logic                  armed, armed_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [FRAME_W-1:0]    shift, shift_nxt;
  logic [DATA_W-1:0]     rd_shift, rd_shift_nxt;
  logic                  rd_frame, rd_frame_nxt;
  logic                  cipo_q, cipo_nxt;
  logic                  cipo_oe_q, cipo_oe_nxt;
  logic [NUM_REGS*DATA_W-1:0] regs_nxt;
  logic [NUM_REGS-1:0]   strobe_nxt;
  logic                  err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      cnt       <= '0;
      shift     <= '0;
      rd_shift  <= '0;
      rd_frame  <= 1'b0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      regs_flat <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      armed     <= armed_nxt;
      cnt       <= cnt_nxt;
      shift     <= shift_nxt;
      rd_shift  <= rd_shift_nxt;
      rd_frame  <= rd_frame_nxt;
      cipo_q    <= cipo_nxt;
      cipo_oe_q <= cipo_oe_nxt;
      regs_flat <= regs_nxt;
      wr_strobe <= strobe_nxt;
      frame_err <= err_nxt;
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

  // Field views: committed frame (shift) and the one about to be shifted (shift_in)
  logic [FRAME_W-1:0] shift_in_c;
  logic               f_rw_c, n_rw_c;
  logic [ADDR_W-1:0]  f_addr_c, n_addr_c;
  logic [DATA_W-1:0]  f_data_c, rd_val_c;

  assign shift_in_c = {shift[FRAME_W-2:0], copi_s};
  assign f_rw_c     = shift[FRAME_W-1];
  assign f_addr_c   = shift[FRAME_W-2 -: ADDR_W];
  assign f_data_c   = shift[DATA_W-1:0];
  assign n_rw_c     = shift_in_c[ADDR_W];
  assign n_addr_c   = shift_in_c[ADDR_W-1:0];

  // Readback mux; unimplemented addresses read as zero
  always_comb begin
    rd_val_c = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (n_addr_c == ADDR_W'(k)) rd_val_c = regs_flat[k*DATA_W +: DATA_W];
    end
  end

  // Next-state: ncs fall arms, ncs rise commits (and wins over any sclk edge)
  always_comb begin
    armed_nxt    = armed;
    cnt_nxt      = cnt;
    shift_nxt    = shift;
    rd_shift_nxt = rd_shift;
    rd_frame_nxt = rd_frame;
    cipo_nxt     = cipo_q;
    regs_nxt     = regs_flat;
    strobe_nxt   = '0;
    err_nxt      = 1'b0;

    if (ncs_fall_c) begin
      armed_nxt    = 1'b1;
      cnt_nxt      = '0;
      shift_nxt    = '0;
      rd_shift_nxt = '0;
      rd_frame_nxt = 1'b0;
      cipo_nxt     = 1'b0;
    end else if (ncs_rise_c) begin
      armed_nxt    = 1'b0;
      rd_frame_nxt = 1'b0;
      cipo_nxt     = 1'b0;
      if (armed) begin
        if (cnt != CNT_LAST) begin
          err_nxt = 1'b1;
        end else if (f_rw_c) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (f_addr_c == ADDR_W'(k)) begin
              regs_nxt[k*DATA_W +: DATA_W] = f_data_c;
              strobe_nxt[k]                = 1'b1;
            end
          end
        end
      end
    end else if (armed && !ncs_s) begin
      if (sclk_rise_c) begin
        shift_nxt = shift_in_c;
        if (cnt != CNT_SAT) cnt_nxt = cnt + CNT_W'(1);
        // Last address bit just arrived: latch readback on a read frame
        if (cnt == CNT_ADDR && !n_rw_c) begin
          rd_frame_nxt = 1'b1;
          rd_shift_nxt = rd_val_c;
        end
      end else if (sclk_fall_c) begin
        if (rd_frame && cnt >= CNT_DATA && cnt < CNT_LAST) begin
          cipo_nxt     = rd_shift[DATA_W-1];
          rd_shift_nxt = {rd_shift[DATA_W-2:0], 1'b0};
        end else begin
          cipo_nxt = 1'b0;
        end
      end
    end

    cipo_oe_nxt = armed_nxt & ~ncs_s;
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised bench for spi_reg_bank: a default-parameter instance and a
// 4-bit address / 16-bit data / 16-register instance, each against an array model.
module tb_spi_reg_bank;

  localparam int H = 6; // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_bank_if spi0 ();
  spi_reg_bank_if spi1 ();

  logic [39:0]  rf0;
  logic [4:0]   ws0;
  logic         fe0;
  logic [255:0] rf1;
  logic [15:0]  ws1;
  logic         fe1;

  spi_reg_bank dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi0.slave),
    .regs_flat (rf0),
    .wr_strobe (ws0),
    .frame_err (fe0)
  );

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16), .SYNC_STAGES(2)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi1.slave),
    .regs_flat (rf1),
    .wr_strobe (ws1),
    .frame_err (fe1)
  );

  int n_vec = 0;
  int n_err = 0;
  int unsigned m0 [5];
  int unsigned m1 [16];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int aw_of(input int sel); return (sel != 0) ? 4 : 7; endfunction
  function automatic int dw_of(input int sel); return (sel != 0) ? 16 : 8; endfunction
  function automatic int nr_of(input int sel); return (sel != 0) ? 16 : 5; endfunction

  function automatic int unsigned model_rd(input int sel, input int unsigned a);
    if (a >= nr_of(sel)) return 0;
    return (sel != 0) ? m1[a] : m0[a];
  endfunction

  function automatic logic [255:0] model_flat(input int sel);
    logic [255:0] v = '0;
    for (int k = 0; k < nr_of(sel); k++)
      v = v | (256'(model_rd(sel, k)) << (k * dw_of(sel)));
    return v;
  endfunction

  function automatic logic [255:0] dut_flat(input int sel);
    return (sel != 0) ? rf1 : 256'(rf0);
  endfunction

  task automatic clear_models();
    foreach (m0[k]) m0[k] = 0;
    foreach (m1[k]) m1[k] = 0;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ncs(input int sel, input logic v);
    if (sel != 0) spi1.ncs = v; else spi0.ncs = v;
  endtask

  task automatic set_sclk(input logic v);
    spi0.sclk = v;
    spi1.sclk = v;
  endtask

  task automatic set_copi(input logic v);
    spi0.copi = v;
    spi1.copi = v;
  endtask

  // Send one frame of len bits; rst_at >= 0 pulses reset just before that bit.
  task automatic send_frame(input int sel, input bit rw, input int unsigned addr,
                            input int unsigned data, input int len, input int rst_at);
    int aw, dw, nr, fw, n_s, n_e;
    logic [63:0]  fv;
    logic [31:0]  rdata;
    logic [255:0] exp_ws, last_ws;
    logic         b, exp_c, armed_m;
    aw = aw_of(sel);
    dw = dw_of(sel);
    nr = nr_of(sel);
    fw = 1 + aw + dw;
    data = data & ((32'd1 << dw) - 1);
    fv = (64'(rw) << (aw + dw)) | (64'(addr) << dw) | 64'(data);
    rdata = model_rd(sel, addr);
    armed_m = 1'b1;

    set_ncs(sel, 1'b0);
    wclk(H);
    chk("cipo_oe_active", (sel != 0) ? spi1.cipo_oe : spi0.cipo_oe, 1'b1);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        wclk(2);
        rst_n = 1'b1;
        clear_models();
        armed_m = 1'b0;
        wclk(2);
      end
      b = (i < fw) ? fv[fw-1-i] : 1'($urandom_range(0, 1));
      set_copi(b);
      wclk(H);
      exp_c = (armed_m && !rw && i > aw && i < fw) ? rdata[fw-1-i] : 1'b0;
      chk("cipo_bit", (sel != 0) ? spi1.cipo : spi0.cipo, exp_c);
      set_sclk(1'b1);
      wclk(H);
      set_sclk(1'b0);
    end
    wclk(H);
    set_ncs(sel, 1'b1);

    exp_ws = '0;
    if (armed_m && len == fw && rw && addr < nr) begin
      exp_ws = 256'(1) << addr;
      if (sel != 0) m1[addr] = data; else m0[addr] = data;
    end

    n_s = 0;
    n_e = 0;
    last_ws = '0;
    for (int c = 0; c < 12; c++) begin
      wclk(1);
      if (((sel != 0) ? 256'(ws1) : 256'(ws0)) != 0) begin
        n_s++;
        last_ws = (sel != 0) ? 256'(ws1) : 256'(ws0);
      end
      if (((sel != 0) ? fe1 : fe0) == 1'b1) n_e++;
    end
    chk("strobe_cycles", n_s, (exp_ws != 0) ? 1 : 0);
    chk("strobe_value", last_ws, exp_ws);
    chk("frame_err_pulses", n_e, (armed_m && len != fw) ? 1 : 0);
    chk("regs_flat", dut_flat(sel), model_flat(sel));
    chk("cipo_idle", (sel != 0) ? spi1.cipo : spi0.cipo, 1'b0);
    chk("cipo_oe_idle", (sel != 0) ? spi1.cipo_oe : spi0.cipo_oe, 1'b0);
  endtask

  initial begin
    int sel, fw, len;
    bit rw;
    int unsigned addr, data;

    set_sclk(1'b0);
    set_copi(1'b0);
    spi0.ncs = 1'b1;
    spi1.ncs = 1'b1;
    clear_models();
    rst_n = 1'b0;
    wclk(4);
    rst_n = 1'b1;
    wclk(6);

    chk("rst_regs0", 256'(rf0), '0);
    chk("rst_ws0", ws0, '0);
    chk("rst_fe0", fe0, 1'b0);
    chk("rst_cipo0", spi0.cipo, 1'b0);
    chk("rst_oe0", spi0.cipo_oe, 1'b0);
    chk("rst_regs1", rf1, '0);
    chk("rst_ws1", ws1, '0);
    chk("rst_oe1", spi1.cipo_oe, 1'b0);

    // Directed cases
    send_frame(0, 1'b1, 0, 'hA5, 16, -1);
    send_frame(0, 1'b1, 4, 'h80, 16, -1);
    send_frame(0, 1'b0, 4, 'h00, 16, -1);
    send_frame(0, 1'b1, 1, 'h3C, 15, -1);
    send_frame(0, 1'b1, 1, 'h3C, 17, -1);
    send_frame(0, 1'b1, 'h10, 'hFF, 16, -1);
    send_frame(0, 1'b0, 'h10, 'h00, 16, -1);
    send_frame(0, 1'b1, 3, 'h5A, 16, 8);
    send_frame(0, 1'b1, 2, 'h33, 16, -1);
    send_frame(1, 1'b1, 15, 'hBEEF, 21, -1);
    send_frame(1, 1'b0, 15, 'h0000, 21, -1);

    // Random frames on both instances, occasionally of the wrong length
    for (int t = 0; t < 50; t++) begin
      sel  = int'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      if (sel != 0) addr = $urandom_range(0, 15);
      else if ($urandom_range(0, 3) == 0) addr = $urandom_range(0, 127);
      else addr = $urandom_range(0, 4);
      data = $urandom;
      fw   = 1 + aw_of(sel) + dw_of(sel);
      len  = fw;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: len = fw - 5;
          1: len = fw - 1;
          2: len = fw + 1;
          default: len = fw + 2;
        endcase
      end
      send_frame(sel, rw, addr, data, len, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
